alu_nx: RTL and testbench
=========================

Name: alu_nx

Overview:
- Parametrised-width successor to the CPU's 8-bit nibble/BCD ALU.
- Adds registered single-cycle ops plus sequential unsigned multiply and divide.
- Start/busy/done handshake and RDY stall, so one unit serves the CPU core and the coprocessor/DMA paths.
- Flags follow 6502 conventions (C, V, Z, N, half-carry), generalised to W bits.

Parameters:
- W, 8: datapath width in bits; must be a multiple of 4 and at least 8.
- CNT_W, $clog2(W+1): iteration counter width; localparam derived from W, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs freeze
- start  in  1  request; accepted when rdy & !busy
- op  in  4  operation code, sampled at accept
- ai  in  W  operand A, sampled at accept
- bi  in  W  operand B, sampled at accept
- ci  in  1  carry in (ADD/SUB/SHL/SHR), sampled at accept
- bcd  in  1  decimal mode for ADD/SUB, sampled at accept
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse; results and flags valid
- out  out  W  result / product low / quotient
- out_hi  out  W  product high / remainder; 0 for single-cycle ops
- co  out  1  carry out
- v  out  1  overflow (signed overflow, or divide-by-zero)
- z  out  1  zero flag
- n  out  1  negative (MSB of most-significant result word)
- hc  out  1  half carry: carry out of nibble 0

Behaviour:
- Reset: busy, done, out, out_hi, co, v, z, n, hc are all 0; FSM goes to IDLE; the counter clears. Reset takes effect immediately and aborts any op in progress.
- Op codes:
  - 0 ADD: A+B+ci.
  - 1 SUB: A+~B+ci (ci=1 means no borrow).
  - 2 SHL: {A[W-2:0],ci}, co=A[W-1].
  - 3 SHR: {ci,A[W-1:1]}, co=A[0].
  - 4 OR, 5 AND, 6 XOR, 7 PASS A.
  - 8 MUL: unsigned W×W -> 2W.
  - 9 DIV: unsigned A/B.
  - 10-15: reserved, executed as PASS A.
- Single-cycle ops (0-7, 10-15): accept at edge k; out, flags and done are valid after edge k+1. busy stays 0. Back-to-back accepts are allowed every cycle.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE -> MUL or DIV on accept of op 8 or 9. busy rises after the accept edge.
  - MUL/DIV run exactly W iterations: radix-2 shift-add, or restoring shift-subtract.
  - After the last iteration -> FIN: busy=0, done=1 for one cycle, outputs updated.
  - FIN -> IDLE. A start presented in FIN is accepted.
- Latency for MUL/DIV: done is valid W+1 rdy-enabled cycles after the accept edge.
- start while busy: ignored, with no side effects.
- rdy=0: the FSM, counter, operand/partial registers, outputs and flags all hold. A done pulse is extended while rdy is low. No accept occurs.
- Flags, ADD/SUB:
  - co = carry out of bit W-1 (after decimal adjust when bcd=1).
  - v = signed binary overflow, computed before decimal adjust.
  - n = out[W-1]; z = (out==0); hc = nibble-0 carry.
- Flags, logic/PASS: co=0, v=0, hc=0.
- Flags, MUL: {out_hi,out} = product; co = |out_hi; v=0; z = (product==0); n = out_hi[W-1].
- Flags, DIV: out = quotient, out_hi = remainder, co=0.
  - B==0: out = all ones, out_hi = A, v=1, and it still takes W+1 cycles.
  - z = (quotient==0); n = out[W-1].
- Decimal mode (bcd=1, ADD/SUB only):
  - Operands are treated as W/4 BCD digits with per-nibble carry chain.
  - ADD: a nibble sum >9 or with a nibble carry gets +6 and carry forward.
  - SUB: a nibble with a borrow gets -6.
  - Invalid BCD digits give an undefined result, but the op still completes in 1 cycle.

Optional Feature:
- Macro ALU_NX_BCD_EN.
- Defined: decimal adjust is implemented as described above.
- Undefined: the bcd input is ignored and ADD/SUB are always binary. hc still reports the binary nibble-0 carry. No decimal-adjust logic is synthesised.

Decomposition:
- Package alu_nx_pkg:
  - Op code constants: OP_ADD…OP_DIV.
  - FSM state enum: IDLE/MUL/DIV/FIN.
  - Flag index constants.
- Sub-module alu_nx_muldiv: holds the iterative multiply/divide datapath, counter and partial registers. Ports: go, is_div, a, b, rdy, last, hi, lo, dz.
- Top level holds the single-cycle datapath, decimal adjust, FSM, flag registers and handshake.

Test Plan (W=8):
- ADD bcd=1, ai=0x58, bi=0x46, ci=1 -> next cycle out=0x05, co=1, hc=1, done=1, busy=0.
- ADD bcd=0, ai=0x7F, bi=0x01, ci=0 -> out=0x80, v=1, n=1, co=0, z=0. SUB ai=0x10, bi=0x10, ci=1 -> out=0x00, z=1, co=1.
- MUL ai=0xFF, bi=0xFF -> busy for 8 cycles, done 9 cycles after accept, out_hi=0xFE, out=0x01, co=1, n=1. A start asserted mid-op is ignored.
- DIV ai=200, bi=7 -> out=28, out_hi=4, v=0. DIV ai=0x55, bi=0 -> out=0xFF, out_hi=0x55, v=1, same latency.
- MUL 0x12×0x34 with rdy low for 3 cycles mid-op -> done at cycle 12 after accept, {out_hi,out}=0x03A8, outputs stable throughout the stall.
- Reset asserted mid-DIV -> busy, done and all outputs 0 immediately. After release, ADD 0x01+0x01 -> 0x02 with 1-cycle latency.

Source files
------------

// File: rtl/alu_nx_pkg.sv
// Shared definitions for the alu_nx arithmetic unit: op codes, FSM states,
// flag bit positions and op classification.
package alu_nx_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_H = 4;
    localparam int NFLAGS = 5;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_nx_muldiv.sv
// Iterative unsigned W x W multiply (radix-2 shift-add) and restoring divide.
// Takes exactly W rdy-enabled iterations after go; last flags the final one.
module alu_nx_muldiv
    import alu_nx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rdy,
    input  logic         go,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dz
);

    localparam int CNT_W = $clog2(W + 1);

    logic             run;
    logic             div_q;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     b_q;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             div_ge;

    // hi:lo is the product accumulator for MUL and remainder:quotient for DIV
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        div_shift = {hi, lo[W-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift - {1'b0, b_q};
    end

    assign last = run && (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run   <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            dz    <= 1'b0;
        end else if (rdy) begin
            if (go) begin
                run   <= 1'b1;
                div_q <= is_div;
                cnt   <= '0;
                b_q   <= b;
                hi    <= '0;
                lo    <= a;
                dz    <= (b == '0);
            end else if (run) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    run <= 1'b0;
                end
                if (div_q) begin
                    // divide by zero needs no special case: every step "fits"
                    hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                    lo <= {lo[W-2:0], div_ge};
                end else begin
                    hi <= mul_sum[W:1];
                    lo <= {mul_sum[0], lo[W-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/alu_nx.sv
// Parametrised-width ALU with 6502-style flags, single-cycle ops and sequential
// MUL/DIV. Define ALU_NX_BCD_EN to build the decimal-adjust path for ADD/SUB.
module alu_nx
    import alu_nx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rdy,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] bi,
    input  logic         ci,
    input  logic         bcd,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic [W-1:0] out_hi,
    output logic         co,
    output logic         v,
    output logic         z,
    output logic         n,
    output logic         hc
);

    state_t              state_q, state_d;
    logic                accept, go_md;
    logic                s1_valid;
    logic [3:0]          s1_op;
    logic [W-1:0]        s1_a, s1_b;
    logic                s1_ci;
    logic                fin_div;
    logic                md_last, md_dz;
    logic [W-1:0]        md_hi, md_lo;
    logic [W-1:0]        bb;
    logic [W:0]          bin_sum;
    logic [4:0]          nib0;
    logic [W-1:0]        res;
    logic [NFLAGS-1:0]   res_flags, md_flags, flags_q;
    logic [W-1:0]        out_q, out_hi_q;
    logic                done_q;

    assign busy   = (state_q == MUL) || (state_q == DIV);
    assign accept = rdy && start && !busy;
    assign go_md  = accept && is_multi(op);

    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign done   = done_q;
    assign co     = flags_q[FLAG_C];
    assign v      = flags_q[FLAG_V];
    assign z      = flags_q[FLAG_Z];
    assign n      = flags_q[FLAG_N];
    assign hc     = flags_q[FLAG_H];

    alu_nx_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .rdy    (rdy),
        .go     (go_md),
        .is_div (op == OP_DIV),
        .a      (ai),
        .b      (bi),
        .last   (md_last),
        .hi     (md_hi),
        .lo     (md_lo),
        .dz     (md_dz)
    );

    assign bb      = (s1_op == OP_SUB) ? ~s1_b : s1_b;
    assign bin_sum = {1'b0, s1_a} + {1'b0, bb} + {{W{1'b0}}, s1_ci};
    assign nib0    = {1'b0, s1_a[3:0]} + {1'b0, bb[3:0]} + {4'b0, s1_ci};

`ifdef ALU_NX_BCD_EN
    logic         s1_bcd;
    logic [W-1:0] dec_sum;
    logic         dec_c, dec_h;
    logic         dec_carry;
    logic [4:0]   dec_t;

    // Nibble-serial decimal chain: ADD adds 6 above 9, SUB subtracts 6 on borrow
    always_comb begin
        dec_sum   = '0;
        dec_h     = 1'b0;
        dec_carry = s1_ci;
        dec_t     = '0;
        for (int i = 0; i < W / 4; i++) begin
            dec_t = {1'b0, s1_a[4*i +: 4]} + {1'b0, bb[4*i +: 4]} + {4'b0, dec_carry};
            if (s1_op == OP_SUB) begin
                dec_carry = dec_t[4];
                if (!dec_t[4]) begin
                    dec_t = dec_t - 5'd6;
                end
            end else if (dec_t > 5'd9) begin
                dec_t     = dec_t + 5'd6;
                dec_carry = 1'b1;
            end else begin
                dec_carry = 1'b0;
            end
            dec_sum[4*i +: 4] = dec_t[3:0];
            if (i == 0) begin
                dec_h = dec_carry;
            end
        end
        dec_c = dec_carry;
    end
`else
    logic bcd_unused;
    assign bcd_unused = bcd;
`endif

    always_comb begin
        res       = s1_a;
        res_flags = '0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                res               = bin_sum[W-1:0];
                res_flags[FLAG_C] = bin_sum[W];
                res_flags[FLAG_V] = (s1_a[W-1] == bb[W-1]) && (bin_sum[W-1] != s1_a[W-1]);
                res_flags[FLAG_H] = nib0[4];
`ifdef ALU_NX_BCD_EN
                if (s1_bcd) begin
                    res               = dec_sum;
                    res_flags[FLAG_C] = dec_c;
                    res_flags[FLAG_H] = dec_h;
                end
`endif
            end
            OP_SHL: begin
                res               = {s1_a[W-2:0], s1_ci};
                res_flags[FLAG_C] = s1_a[W-1];
            end
            OP_SHR: begin
                res               = {s1_ci, s1_a[W-1:1]};
                res_flags[FLAG_C] = s1_a[0];
            end
            OP_OR:   res = s1_a | s1_b;
            OP_AND:  res = s1_a & s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            default: res = s1_a;
        endcase
        res_flags[FLAG_Z] = (res == '0);
        res_flags[FLAG_N] = res[W-1];
    end

    always_comb begin
        md_flags = '0;
        if (fin_div) begin
            md_flags[FLAG_V] = md_dz;
            md_flags[FLAG_Z] = (md_lo == '0);
            md_flags[FLAG_N] = md_lo[W-1];
        end else begin
            md_flags[FLAG_C] = |md_hi;
            md_flags[FLAG_Z] = ({md_hi, md_lo} == '0);
            md_flags[FLAG_N] = md_hi[W-1];
        end
    end

    // FIN accepts a new start just like IDLE, so back-to-back MUL/DIV lose no cycle
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                IDLE, FIN: begin
                    state_d = IDLE;
                    if (go_md) begin
                        state_d = (op == OP_DIV) ? DIV : MUL;
                    end
                end
                MUL, DIV: begin
                    if (md_last) begin
                        state_d = FIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Single-cycle ops are staged one cycle so their latency matches the
    // registered-result timing of the FIN publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ci    <= 1'b0;
`ifdef ALU_NX_BCD_EN
            s1_bcd   <= 1'b0;
`endif
            fin_div  <= 1'b0;
            out_q    <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else if (rdy) begin
            s1_valid <= accept && !is_multi(op);
            if (accept) begin
                s1_op  <= op;
                s1_a   <= ai;
                s1_b   <= bi;
                s1_ci  <= ci;
`ifdef ALU_NX_BCD_EN
                s1_bcd <= bcd;
`endif
            end
            if (go_md) begin
                fin_div <= (op == OP_DIV);
            end
            done_q <= 1'b0;
            if (s1_valid) begin
                out_q    <= res;
                out_hi_q <= '0;
                flags_q  <= res_flags;
                done_q   <= 1'b1;
            end else if (state_q == FIN) begin
                out_q    <= md_lo;
                out_hi_q <= md_hi;
                flags_q  <= md_flags;
                done_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_nx.sv
// Scoreboard bench for alu_nx (W=8): stimulus pushes expected results, a
// monitor pops and checks them on every done pulse.
module tb_alu_nx;
    import alu_nx_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic [7:0] out_hi;
        logic       co, v, z, n, hc;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, rdy, start, ci, bcd;
    logic [3:0] op;
    logic [7:0] ai, bi;
    logic       busy, done, co, v, z, n, hc;
    logic [7:0] out, out_hi;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t bcd_add_e, bcd_sub_e;

    alu_nx #(.W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .rdy    (rdy),
        .start  (start),
        .op     (op),
        .ai     (ai),
        .bi     (bi),
        .ci     (ci),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .out_hi (out_hi),
        .co     (co),
        .v      (v),
        .z      (z),
        .n      (n),
        .hc     (hc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string nm, input logic [7:0] o, input logic [7:0] h,
                                input logic fc, input logic fv, input logic fz,
                                input logic fn, input logic fh);
        exp_t e;
        e.name = nm; e.out = o; e.out_hi = h;
        e.co = fc; e.v = fv; e.z = fz; e.n = fn; e.hc = fh;
        e.due = 0;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, expv);
        end
    endtask

    // Drive one request; it is accepted on the next rising edge
    task automatic apply_stimulus(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic c, input logic d, input exp_t e,
                                  input int lat, input bit track);
        start = 1'b1; op = o; ai = a; bi = b; ci = c; bcd = d;
        @(posedge clk);
        #1;
        if (track) begin
            e.due = cyc + lat;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int i;
        i = 0;
        while (sb.size() != 0 && i < limit) begin
            @(posedge clk);
            #1;
            i++;
        end
        check_output("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && rdy && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, wanted no result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check_output({mon_e.name, ".out"},    out,    mon_e.out);
                check_output({mon_e.name, ".out_hi"}, out_hi, mon_e.out_hi);
                check_output({mon_e.name, ".co"},     co,     mon_e.co);
                check_output({mon_e.name, ".v"},      v,      mon_e.v);
                check_output({mon_e.name, ".z"},      z,      mon_e.z);
                check_output({mon_e.name, ".n"},      n,      mon_e.n);
                check_output({mon_e.name, ".hc"},     hc,     mon_e.hc);
                check_output({mon_e.name, ".busy"},   busy,   0);
                check_output({mon_e.name, ".cycle"},  cyc,    mon_e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef ALU_NX_BCD_EN
        bcd_add_e = mk("add_bcd", 8'h05, 8'h00, 1, 1, 0, 0, 1);
        bcd_sub_e = mk("sub_bcd", 8'h25, 8'h00, 1, 0, 0, 0, 0);
`else
        bcd_add_e = mk("add_bcd", 8'h9F, 8'h00, 0, 1, 0, 1, 0);
        bcd_sub_e = mk("sub_bcd", 8'h2B, 8'h00, 1, 0, 0, 0, 0);
`endif
        reset = 1'b1; rdy = 1'b1; start = 1'b0; op = '0;
        ai = '0; bi = '0; ci = 1'b0; bcd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst.busy", busy, 0);
        check_output("rst.done", done, 0);
        check_output("rst.out", out, 0);
        check_output("rst.out_hi", out_hi, 0);
        check_output("rst.flags", {co, v, z, n, hc}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single-cycle ops, back to back");
        apply_stimulus(OP_ADD,  8'h58, 8'h46, 1, 1, bcd_add_e, 1, 1);
        apply_stimulus(OP_ADD,  8'h7F, 8'h01, 0, 0, mk("add_ovf",    8'h80, 0, 0, 1, 0, 1, 1), 1, 1);
        apply_stimulus(OP_SUB,  8'h10, 8'h10, 1, 0, mk("sub_zero",   8'h00, 0, 1, 0, 1, 0, 1), 1, 1);
        apply_stimulus(OP_SUB,  8'h05, 8'h10, 1, 0, mk("sub_borrow", 8'hF5, 0, 0, 0, 0, 1, 1), 1, 1);
        apply_stimulus(OP_SUB,  8'h42, 8'h17, 1, 1, bcd_sub_e, 1, 1);
        apply_stimulus(OP_SHL,  8'h81, 8'h00, 1, 0, mk("shl",  8'h03, 0, 1, 0, 0, 0, 0), 1, 1);
        apply_stimulus(OP_SHR,  8'h81, 8'h00, 1, 0, mk("shr",  8'hC0, 0, 1, 0, 0, 1, 0), 1, 1);
        apply_stimulus(OP_OR,   8'hF0, 8'h0F, 0, 0, mk("or",   8'hFF, 0, 0, 0, 0, 1, 0), 1, 1);
        apply_stimulus(OP_AND,  8'hF0, 8'h0F, 0, 0, mk("and",  8'h00, 0, 0, 0, 1, 0, 0), 1, 1);
        apply_stimulus(OP_XOR,  8'hAA, 8'hFF, 0, 0, mk("xor",  8'h55, 0, 0, 0, 0, 0, 0), 1, 1);
        apply_stimulus(OP_PASS, 8'h80, 8'h11, 1, 0, mk("pass", 8'h80, 0, 0, 0, 0, 1, 0), 1, 1);
        apply_stimulus(4'd12,   8'h3C, 8'h11, 1, 0, mk("rsvd", 8'h3C, 0, 0, 0, 0, 0, 0), 1, 1);
        wait_drain(20);

        $display("[TB] MUL 0xFF*0xFF with an ignored start mid-op");
        apply_stimulus(OP_MUL, 8'hFF, 8'hFF, 0, 0, mk("mul_ff", 8'h01, 8'hFE, 1, 0, 0, 1, 0), 9, 1);
        @(negedge clk);
        check_output("mul.busy_after_accept", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b1; op = OP_ADD; ai = 8'h01; bi = 8'h01; ci = 1'b0; bcd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(30);

        $display("[TB] DIV cases");
        apply_stimulus(OP_DIV, 8'd200, 8'd7, 0, 0, mk("div_200_7", 8'd28, 8'd4, 0, 0, 0, 0, 0), 9, 1);
        wait_drain(30);
        apply_stimulus(OP_DIV, 8'h55, 8'h00, 0, 0, mk("div_by_0", 8'hFF, 8'h55, 0, 1, 0, 1, 0), 9, 1);
        wait_drain(30);

        $display("[TB] MUL with a 3-cycle rdy stall");
        apply_stimulus(OP_MUL, 8'h12, 8'h34, 0, 0, mk("mul_stall", 8'hA8, 8'h03, 1, 0, 0, 0, 0), 12, 1);
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall.out", out, 8'hFF);
            check_output("stall.out_hi", out_hi, 8'h55);
            check_output("stall.busy", busy, 1);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        wait_drain(30);

        $display("[TB] reset during DIV");
        apply_stimulus(OP_DIV, 8'h90, 8'h05, 0, 0, mk("div_aborted", 0, 0, 0, 0, 0, 0, 0), 9, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("abort.busy", busy, 0);
        check_output("abort.done", done, 0);
        check_output("abort.out", out, 0);
        check_output("abort.out_hi", out_hi, 0);
        check_output("abort.flags", {co, v, z, n, hc}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(OP_ADD, 8'h01, 8'h01, 0, 0, mk("add_after_rst", 8'h02, 0, 0, 0, 0, 0, 0), 1, 1);
        wait_drain(20);

        repeat (15) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
